// File: rtl/sdrc_app_arbiter.sv
// sdrc_app_arbiter: two-requester round-robin arbiter for the SDRAM controller
// application port. Each grant carries one burst: a command phase (CMD) followed
// by the write or read data phase (XFER). The arbiter does not re-arbitrate until
// the burst's last beat has been seen. It flags bursts whose beat count differs
// from the requested length, and also flags zero-length requests.
//
// Handshake semantics (all signals sampled on the rising edge of clk):
//   req[i] is held by requester i until it sees req_ack[i] high for one cycle.
//   app_req is held with stable addr/len/dir until the controller returns
//   app_req_ack; that same cycle is the command transfer.
//   A write beat transfers in any XFER cycle with app_wr_next high. A read beat
//   transfers in any XFER cycle with app_rd_valid high. No back-pressure exists
//   on the data phase.
// dbg_state exposes the FSM encoding (0=IDLE, 1=CMD, 2=XFER) for checkers.
module sdrc_app_arbiter #(
    parameter int APP_AW = 30,
    parameter int APP_DW = 32,
    parameter int APP_BW = 4,
    parameter int BL_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req,
    input  logic [2*APP_AW-1:0]   req_addr,
    input  logic [2*BL_W-1:0]     req_len,
    input  logic [1:0]            req_wr_n,
    output logic [1:0]            req_ack,
    input  logic [2*APP_DW-1:0]   wr_data,
    input  logic [2*APP_BW-1:0]   wr_en_n,
    output logic [1:0]            wr_next,
    output logic [APP_DW-1:0]     rd_data,
    output logic [1:0]            rd_valid,
    output logic                  len_err,
    output logic                  busy,
    output logic                  app_req,
    output logic [APP_AW-1:0]     app_req_addr,
    output logic [BL_W-1:0]       app_req_len,
    output logic                  app_req_wr_n,
    input  logic                  app_req_ack,
    output logic [APP_DW-1:0]     app_wr_data,
    output logic [APP_BW-1:0]     app_wr_en_n,
    input  logic                  app_wr_next,
    input  logic                  app_last_wr,
    input  logic [APP_DW-1:0]     app_rd_data,
    input  logic                  app_rd_valid,
    input  logic                  app_last_rd,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    state_t state, state_next;

    logic              grant;
    logic              last_grant;
    logic [APP_AW-1:0] addr_q;
    logic [BL_W-1:0]   len_q;
    logic              wr_n_q;
    logic [BL_W:0]     beat_cnt;
    logic              len_err_q;

    logic              arb_valid;
    logic              arb_g;
    logic [BL_W-1:0]   arb_len;
    logic              arb_zero;
    logic              arb_take;
    logic              beat;
    logic              burst_end;
    logic [BL_W+1:0]   cnt_inc;

    // Round-robin pick: a lone requester wins; on contention the one not served last wins.
    always_comb begin
        arb_valid = |req;
        arb_g     = 1'b0;
        case (req)
            2'b01:   arb_g = 1'b0;
            2'b10:   arb_g = 1'b1;
            2'b11:   arb_g = ~last_grant;
            default: arb_g = 1'b0;
        endcase
        arb_len = arb_g ? req_len[2*BL_W-1:BL_W] : req_len[BL_W-1:0];
        // Zero-length requests are answered in IDLE without touching the controller.
        // Reset gating keeps this combinational path quiet while reset is held.
        arb_zero = (state == ST_IDLE) && arb_valid && (arb_len == '0) && !reset;
        arb_take = (state == ST_IDLE) && arb_valid && (arb_len != '0);
    end

    // Data-phase beat and burst-end detection, qualified by the latched direction.
    always_comb begin
        beat      = 1'b0;
        burst_end = 1'b0;
        if (state == ST_XFER) begin
            if (!wr_n_q) begin
                beat      = app_wr_next;
                burst_end = app_wr_next & app_last_wr;
            end else begin
                beat      = app_rd_valid;
                burst_end = app_rd_valid & app_last_rd;
            end
        end
        cnt_inc = {1'b0, beat_cnt} + {{(BL_W+1){1'b0}}, 1'b1};
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (arb_take)    state_next = ST_CMD;
            ST_CMD:  if (app_req_ack) state_next = ST_XFER;
            ST_XFER: if (burst_end)   state_next = ST_IDLE;
            default:                  state_next = ST_IDLE;
        endcase
    end

    // Grant bookkeeping and latching of the granted command fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            addr_q     <= '0;
            len_q      <= '0;
            wr_n_q     <= 1'b0;
        end else begin
            if (arb_take) begin
                grant  <= arb_g;
                addr_q <= arb_g ? req_addr[2*APP_AW-1:APP_AW] : req_addr[APP_AW-1:0];
                len_q  <= arb_len;
                wr_n_q <= req_wr_n[arb_g];
            end else if (arb_zero) begin
                grant      <= arb_g;
                last_grant <= arb_g;
            end
            if (burst_end) begin
                last_grant <= grant;
            end
        end
    end

    // Beat counter (saturating) and the registered length-mismatch flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt  <= '0;
            len_err_q <= 1'b0;
        end else begin
            if (state == ST_CMD && app_req_ack) begin
                beat_cnt <= '0;
            end else if (beat && beat_cnt != '1) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            len_err_q <= burst_end && (cnt_inc != {2'b00, len_q});
        end
    end

    // Output muxing and per-requester strobes routed to the granted requester only.
    always_comb begin
        req_ack     = 2'b00;
        wr_next     = 2'b00;
        rd_valid    = 2'b00;
        app_wr_en_n = '1;
        if (arb_zero) begin
            req_ack[arb_g] = 1'b1;
        end
        if (state == ST_CMD && app_req_ack) begin
            req_ack[grant] = 1'b1;
        end
        if (state == ST_XFER) begin
            if (!wr_n_q) begin
                wr_next[grant] = app_wr_next;
                app_wr_en_n    = grant ? wr_en_n[2*APP_BW-1:APP_BW] : wr_en_n[APP_BW-1:0];
            end else begin
                rd_valid[grant] = app_rd_valid;
            end
        end
    end

    assign app_wr_data  = grant ? wr_data[2*APP_DW-1:APP_DW] : wr_data[APP_DW-1:0];
    assign rd_data      = app_rd_data;
    assign app_req      = (state == ST_CMD);
    assign app_req_addr = addr_q;
    assign app_req_len  = len_q;
    assign app_req_wr_n = wr_n_q;
    assign busy         = (state != ST_IDLE);
    assign len_err      = len_err_q | arb_zero;
    assign dbg_state    = state;

endmodule
